prog_loader: RTL
================

# prog_loader

Boot-time program loader that sits in front of the instruction ROM and the CPU core. It receives a framed byte stream over a valid/ready handshake and writes the 9-bit instruction words into instruction memory. It holds the core in reset through `start` until the whole image is loaded and checksum-verified, then releases it. After release it counts execution cycles until the core raises `halt`.

## Interface
Parameters:
- `A`, default 16: instruction-memory address width (words).

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  A  word address for the write.
- `imem_data`  out  9  instruction word for the write.
- `start`  out  1  core reset; high holds the core, low lets it run.
- `halt`  in  1  core halted.
- `busy`  out  1  a load is in progress.
- `done`  out  1  core has halted after a good load (sticky).
- `err`  out  1  frame error (sticky).
- `run_cycles`  out  16  cycles the core ran before halting, saturating.

## Operation
- Frame format, byte order:
  - N_lo, N_hi: 16-bit word count N.
  - N pairs of (LO, HI). Each word is {HI[0], LO}, and HI[7:1] must be 0.
  - One CSUM byte, equal to the XOR of every preceding byte in the frame.
- Handshake: a byte transfers when `in_valid & in_ready`. `in_ready` is combinational from state and is 1 only in HDR_LO, HDR_HI, W_LO, W_HI and CSUM.
- State machine:
  - HDR_LO: store N[7:0], go to HDR_HI.
  - HDR_HI: store N[15:8].
    - If N > 2**A, go to ERR.
    - Else if N == 0, go to CSUM.
    - Else go to W_LO.
  - W_LO: store LO, go to W_HI.
  - W_HI: if HI[7:1] != 0, go to ERR with no write for that word. Otherwise:
    - Register a write of `imem_addr` = index and `imem_data` = {HI[0], LO}.
    - Increment the index.
    - Go to CSUM when this was word N-1, else to W_LO.
  - CSUM: if the byte matches the running XOR, go to RUN; otherwise go to ERR.
  - RUN: `start` = 0. `run_cycles` increments each cycle while `halt` is 0 and saturates at 0xFFFF. When `halt` is 1, go to DONE.
  - DONE: `done` = 1 and `start` = 0. Held until reset.
  - ERR: `err` = 1 and `start` = 1, so the core stays held. Held until reset.
- The running XOR and word index clear on reset only; one frame is accepted per reset.
- `halt` is ignored outside RUN.
- `busy` = 1 in HDR_LO through CSUM.

## Timing
- Reset values: state HDR_LO, `in_ready` = 1, `imem_we` = 0, `imem_addr` = 0, `imem_data` = 0, `start` = 1, `busy` = 1, `done` = 0, `err` = 0, `run_cycles` = 0.
- Throughput: one byte per cycle with `in_valid` held high. A full load takes 2N+3 accepted bytes.
- Writes:
  - `imem_we` pulses for exactly one cycle, in the cycle after the W_HI handshake, with address and data valid in that same cycle.
  - There are never two consecutive writes to the same address.
- `start` falls in the cycle after the accepted good CSUM byte.
- `err` rises in the cycle after the offending byte is accepted. `in_ready` is 0 from that cycle on.
- `done` rises in the cycle after `halt` is sampled high in RUN. `run_cycles` freezes in that same cycle.
- A stall (`in_valid` = 0) in any receive state holds all state. No write or counter change occurs.
- `reset_n` low mid-operation: all outputs go to their reset values immediately (asynchronously), so `imem_we` drops at once. Words already written to memory are not erased.

## Test plan
- Good load, back-to-back bytes 03 00 A5 01 FF 00 00 01 59 -> writes (0, 0x1A5), (1, 0x0FF), (2, 0x100) on three single-cycle strobes; `start` falls one cycle after 59; `busy` = 0.
- Same frame with CSUM 58 -> `err` = 1, `start` stays 1, `in_ready` = 0, three writes still occurred, no `done` even if `halt` pulses.
- Bad high byte: 01 00 12 03 -> ERR after 03, `imem_we` never asserts.
- Empty image 00 00 00 -> RUN with no writes; raise `halt` 10 cycles after `start` falls -> `run_cycles` = 10, `done` = 1 next cycle.
- Good frame delivered with random `in_valid` gaps -> identical write sequence to the first scenario, no duplicate or extra strobes.
- `reset_n` pulsed low after the LO byte of word 1 -> outputs at reset values immediately; a following full good frame loads and releases `start` normally.

Source files
------------

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream boot loader with checksum gate and run-cycle counter
module prog_loader #(
    parameter int A = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         imem_we,
    output logic [A-1:0] imem_addr,
    output logic [8:0]   imem_data,
    output logic         start,
    input  logic         halt,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [15:0]  run_cycles
);

    // Receive states are numbered first so "state <= S_CSUM" means "accepting bytes".
    localparam logic [2:0] S_HDR_LO = 3'd0;
    localparam logic [2:0] S_HDR_HI = 3'd1;
    localparam logic [2:0] S_W_LO   = 3'd2;
    localparam logic [2:0] S_W_HI   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    logic [2:0]   state_q, state_d;
    logic [7:0]   nlo_q, nlo_d;
    logic [15:0]  rem_q, rem_d;
    logic [7:0]   lo_q, lo_d;
    logic [A-1:0] idx_q, idx_d;
    logic [7:0]   csum_q, csum_d;
    logic         imem_we_q, imem_we_d;
    logic [A-1:0] imem_addr_q, imem_addr_d;
    logic [8:0]   imem_data_q, imem_data_d;
    logic [15:0]  run_q, run_d;

    logic         rx_state;
    logic         accept;
    logic [15:0]  n_full;
    logic [32:0]  cap;

    assign rx_state = (state_q <= S_CSUM);
    assign accept   = in_valid & rx_state;
    assign n_full   = {in_data, nlo_q};
    // Largest image that fits the memory: 2**A words.
    assign cap      = 33'd1 << A;

    // Next-state, datapath and write-strobe computation; everything holds unless a byte is accepted.
    always_comb begin
        state_d     = state_q;
        nlo_d       = nlo_q;
        rem_d       = rem_q;
        lo_d        = lo_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        imem_we_d   = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;
        run_d       = run_q;

        if (accept) begin
            csum_d = csum_q ^ in_data;
        end

        case (state_q)
            S_HDR_LO: begin
                if (accept) begin
                    nlo_d   = in_data;
                    state_d = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (accept) begin
                    rem_d = n_full;
                    if ({17'd0, n_full} > cap) begin
                        state_d = S_ERR;
                    end else if (n_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_W_LO;
                    end
                end
            end
            S_W_LO: begin
                if (accept) begin
                    lo_d    = in_data;
                    state_d = S_W_HI;
                end
            end
            S_W_HI: begin
                if (accept) begin
                    if (in_data[7:1] != 7'd0) begin
                        state_d = S_ERR;
                    end else begin
                        imem_we_d   = 1'b1;
                        imem_addr_d = idx_q;
                        imem_data_d = {in_data[0], lo_q};
                        idx_d       = idx_q + A'(1);
                        rem_d       = rem_q - 16'd1;
                        state_d     = (rem_q == 16'd1) ? S_CSUM : S_W_LO;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? S_RUN : S_ERR;
                end
            end
            S_RUN: begin
                if (halt) begin
                    state_d = S_DONE;
                end else if (run_q != 16'hFFFF) begin
                    run_d = run_q + 16'd1;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // State register; async reset returns every output to its idle value at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_HDR_LO;
            nlo_q       <= 8'd0;
            rem_q       <= 16'd0;
            lo_q        <= 8'd0;
            idx_q       <= '0;
            csum_q      <= 8'd0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= 9'd0;
            run_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            nlo_q       <= nlo_d;
            rem_q       <= rem_d;
            lo_q        <= lo_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
            run_q       <= run_d;
        end
    end

    assign in_ready   = rx_state;
    assign busy       = rx_state;
    assign start      = !((state_q == S_RUN) || (state_q == S_DONE));
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_data  = imem_data_q;
    assign run_cycles = run_q;

endmodule
